// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory write path.
package imem_pkg;

    // Default instruction word width and imem word-address width.
    localparam int unsigned IMEM_N = 32;
    localparam int unsigned IMEM_R = 7;

    localparam int unsigned BYTES_PER_WORD = IMEM_N / 8;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_t;

    // Width of a counter that spans 0..bpw-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned bpw);
        return (bpw > 1) ? $clog2(bpw) : 1;
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Shifts stream bytes into an n-bit word, first byte ending up in the MSBs.
module word_assembler
    import imem_pkg::*;
#(
    parameter int unsigned N = IMEM_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         shift_en,
    input  logic [7:0]   in_byte,
    output logic         word_ready,
    output logic [N-1:0] word_next
);

    localparam int unsigned BPW = N / 8;
    localparam int unsigned CW  = cnt_width(BPW);

    logic [N-1:0]  word_q, word_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Next word value and end-of-word detection on the current transfer.
    always_comb begin
        word_next  = (word_q << 8) | N'(in_byte);
        word_ready = shift_en && (cnt_q == CW'(BPW - 1));
        word_d     = word_q;
        cnt_d      = cnt_q;
        if (clear) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (shift_en) begin
            word_d = word_next;
            cnt_d  = word_ready ? '0 : cnt_q + CW'(1);
        end
    end

    // Assembly register and byte counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Turns a byte stream into consecutive big-endian word writes on the imem port.
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned n = IMEM_N,
    parameter int unsigned r = IMEM_R
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [r-1:0] base_addr,
    input  logic [r:0]   num_words,
    input  logic [7:0]   in_byte,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         we,
    output logic [r-1:0] waddr,
    output logic [n-1:0] wdata,
    output logic         busy,
    output logic         done
);

    state_t         state_q, state_d;
    logic [r-1:0]   addr_q, addr_d;
    logic [r:0]     rem_q, rem_d;
    logic [r-1:0]   waddr_q, waddr_d;
    logic [n-1:0]   wdata_q, wdata_d;

    logic           word_ready;
    logic [n-1:0]   word_next;

    // Handshake and status outputs are pure functions of state.
    assign in_ready = (state_q == RECV);
    assign we       = (state_q == WRITE);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;

    word_assembler #(
        .N(n)
    ) u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (state_q != RECV),
        .shift_en   (in_valid && in_ready),
        .in_byte    (in_byte),
        .word_ready (word_ready),
        .word_next  (word_next)
    );

    // Next-state, address and remaining-word logic.
    // The write port registers are loaded on the final byte so they present
    // the word during WRITE and then hold until the next word completes.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    rem_d   = num_words;
                    state_d = (num_words == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (word_ready) begin
                    waddr_d = addr_q;
                    wdata_d = word_next;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                addr_d  = addr_q + r'(1);
                rem_d   = rem_q - (r + 1)'(1);
                state_d = (rem_q == (r + 1)'(1)) ? DONE : RECV;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: turns a byte stream from the host or boot path into word writes on the imem write port.
- Assembles n/8 bytes into one n-bit instruction word, big-endian. Writes each word to consecutive word addresses starting at a programmable base.
- Signals completion once the requested number of words is stored. Sits between the boot/UART byte source and imem, and is idle during normal instruction fetch.

Parameters:
- n, 32, instruction word width in bits; must be a multiple of 8
- r, 7, imem word-address width (depth 2^r words)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a load; ignored unless in IDLE
- base_addr  input  r  first word address; sampled when start is accepted
- num_words  input  r+1  words to load (0..2^r); sampled when start is accepted
- in_byte  input  8  stream byte
- in_valid  input  1  in_byte is valid
- in_ready  output  1  loader accepts in_byte this cycle
- we  output  1  imem write enable, one-cycle pulse per word
- waddr  output  r  imem write word address
- wdata  output  n  imem write data
- busy  output  1  load in progress (any state except IDLE)
- done  output  1  one-cycle pulse when the last word has been written

Behaviour:
- Reset values: in_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0. State goes to IDLE; byte counter, word counter and assembly register are cleared.
- Reset mid-load discards any partial word. No write issues on the reset cycle or after it.
- Handshake: a byte transfers on a rising edge where in_valid && in_ready. in_ready depends only on state, never on in_valid.
- IDLE:
  - in_ready=0.
  - On start: latch base_addr into the address register and num_words into the remaining-word register, then go to RECV.
  - If num_words==0, go directly to DONE instead.
- RECV:
  - in_ready=1.
  - Each transferred byte shifts into the assembly register: first byte lands in bits [n-1:n-8], last byte in [7:0].
  - The byte counter counts 0..n/8-1. On the transfer of byte n/8-1, go to WRITE.
  - in_valid low stalls indefinitely with no timeout; state is held.
- WRITE (exactly one cycle):
  - in_ready=0; we=1; waddr=current address; wdata=assembled word.
  - Next edge: address increments modulo 2^r (wraps from 2^r-1 to 0), remaining-word count decrements, byte counter clears.
  - Go to DONE if remaining was 1, else RECV.
- DONE (exactly one cycle): done=1, in_ready=0, then go to IDLE.
- waddr and wdata hold their last values outside WRITE. Only we qualifies them.
- Throughput: one word per n/8+1 cycles with in_valid held high. Latency from the last byte's transfer edge to we=1 is 1 cycle. done asserts the cycle after the final we.
- start asserted while busy is ignored; latched parameters stay unchanged.
- start and reset in the same cycle: reset wins.
- num_words=2^r with a nonzero base wraps and fills the entire memory exactly once.

Decomposition:
- Shared package imem_pkg holds:
  - state typedef enum {IDLE, RECV, WRITE, DONE}
  - BYTES_PER_WORD = n/8
  - width constants shared with imem
- One natural sub-module: word_assembler, containing the shift register and byte counter. It has a word_ready output and a clear input.
- The FSM plus address and word counters stay in imem_loader.

Test Plan:
- Basic load: base=0, num_words=2, bytes 8C 01 00 04 20 02 00 05 with in_valid held high.
  - Required: we at address 0 with wdata 8C010004, then we at address 1 with wdata 20020005.
  - done pulses once, one cycle after the second we; busy=0 afterwards.
- Stalled stream: same load with in_valid toggling 1/0 each cycle.
  - Required: identical writes and data; no byte is accepted while in_valid=0; in_ready is low during WRITE and DONE.
- Wrap-around: base=7F, num_words=3, words 11111111, 22222222, 33333333.
  - Required: writes at addresses 7F, 00, 01 in that order.
- Zero length and start-while-busy:
  - start with num_words=0 → done pulses on the cycle after start, with no we and in_ready never high.
  - A second start with base=10 issued during RECV of a load with base=0 is ignored; writes stay at address 0.
- Reset mid-word: reset asserted after 2 of 4 bytes, then a new load with base=5 and word DEADBEEF.
  - Required: no we during or after the reset until the new word completes; a single write of DEADBEEF at address 05; all outputs read 0 during reset.
